pixel_frame_ctrl: RTL and testbench

Parametrised successor to the fixed two-row pixel state machine and ADC/readout model.
- Sequences a full frame: ERASE -> EXPOSE -> CONVERT -> READ for NROWS rows of NCOLS channels each.
- Drives the shared ramp ADC code onto the tristated pixel buses and captures each row into a valid/ready output stream.
- Adds programmable exposure, a start/continuous mode, and backpressure.
- Sits between the pixel array (read/control/bus side) and the downstream frame consumer.

---
 rtl/pixel_ctrl_pkg.sv | 19 +
 rtl/pixel_ramp_adc.sv | 44 ++++
 rtl/pixel_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pixel_frame_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and helpers for the pixel frame controller.
package pixel_ctrl_pkg;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ,
        HOLD
    } state_e;

    // Bit offset of a row's bus slice in the row-major pixel bus.
    function automatic int row_lsb(input int row, input int ncols, input int dw);
        return row * ncols * dw;
    endfunction

endpackage

// File: rtl/pixel_ramp_adc.sv
// Shared ramp ADC model: code counter running only during conversion,
// plus clock-gated models of the ramp and bias analog signals.
module pixel_ramp_adc #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          convert_i,
    input  logic          expose_i,
    output logic [DW-1:0] code_o,
    output logic          last_o,
    output logic          anaRamp_o,
    output logic          anaBias1_o
);

    logic [DW-1:0] code_q;
    logic [DW-1:0] code_d;

    // Last conversion cycle: the ramp has reached full scale.
    assign last_o = convert_i && (code_q == {DW{1'b1}});

    // Ramp up by one per convert cycle; held at zero outside conversion and
    // returned to zero at the exit edge instead of wrapping.
    always_comb begin
        code_d = '0;
        if (convert_i && !last_o) begin
            code_d = code_q + DW'(1);
        end
    end

    // Code register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q <= '0;
        end else begin
            code_q <= code_d;
        end
    end

    assign code_o     = code_q;
    assign anaRamp_o  = convert_i & clk;
    assign anaBias1_o = expose_i & clk;

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ramp-convert, then read
// each row onto a valid/ready stream. Non-read rows are driven with the ramp code.
//
// Output stream handshake: a row transfers on a rising clk edge where
// out_valid && out_ready. out_valid rises only after a row is captured, and
// once high it stays high with out_data/out_row stable until that transfer
// (or reset). out_ready is ignored while out_valid is low.
module pixel_frame_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int DW        = 8,
    parameter int NROWS     = 2,
    parameter int NCOLS     = 2,
    parameter int ERASE_CYC = 5,
    parameter int EXP_W     = 16,
    localparam int RW       = NCOLS * DW,
    localparam int ROWB     = (NROWS > 1) ? $clog2(NROWS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cont,
    input  logic [EXP_W-1:0]      exp_cycles,
    output logic                  erase,
    output logic                  expose,
    output logic                  convert,
    output logic [NROWS-1:0]      read,
    output logic                  anaBias1,
    output logic                  anaRamp,
    inout  wire  [NROWS*RW-1:0]   pixData,
    output logic [RW-1:0]         out_data,
    output logic [ROWB-1:0]       out_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  busy,
    output logic [2:0]            state_dbg
);

    localparam logic [EXP_W-1:0] ERASE_LAST = EXP_W'(ERASE_CYC - 1);
    localparam logic [ROWB-1:0]  ROW_LAST   = ROWB'(NROWS - 1);

    state_e             state_q, state_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [ROWB-1:0]    row_q, row_d;
    logic [RW-1:0]      odata_q, odata_d;
    logic [ROWB-1:0]    orow_q, orow_d;
    logic               ovalid_q, ovalid_d;
    logic               fdone_q, fdone_d;

    logic [DW-1:0]      adc_code;
    logic               adc_last;
    logic [EXP_W-1:0]   exp_eff;
    logic [RW-1:0]      row_bus [NROWS];

    // A zero exposure request still exposes for one cycle.
    assign exp_eff = (exp_cycles == '0) ? EXP_W'(1) : exp_cycles;

    pixel_ramp_adc #(.DW(DW)) u_adc (
        .clk        (clk),
        .reset      (reset),
        .convert_i  (convert),
        .expose_i   (expose),
        .code_o     (adc_code),
        .last_o     (adc_last),
        .anaRamp_o  (anaRamp),
        .anaBias1_o (anaBias1)
    );

    // Per-row bus: release only the row being read, drive every other row
    // with the ramp code on all channels.
    for (genvar r = 0; r < NROWS; r++) begin : g_row
        assign read[r]  = (state_q == READ) && (row_q == ROWB'(r));
        assign pixData[row_lsb(r, NCOLS, DW) +: RW] =
            read[r] ? {RW{1'bz}} : {NCOLS{adc_code}};
        assign row_bus[r] = pixData[row_lsb(r, NCOLS, DW) +: RW];
    end

    // Next-state, counters and output-register updates for the frame sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        row_d    = row_q;
        odata_d  = odata_q;
        orow_d   = orow_q;
        ovalid_d = ovalid_q;
        fdone_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ERASE;
                    cnt_d   = '0;
                    exp_d   = exp_eff;
                end
            end
            ERASE: begin
                if (cnt_q == ERASE_LAST) begin
                    state_d = EXPOSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + EXP_W'(1);
                end
            end
            EXPOSE: begin
                if (cnt_q == exp_q - EXP_W'(1)) begin
                    state_d = CONVERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + EXP_W'(1);
                end
            end
            CONVERT: begin
                if (adc_last) begin
                    state_d = READ;
                    row_d   = '0;
                end
            end
            READ: begin
                odata_d  = row_bus[row_q];
                orow_d   = row_q;
                ovalid_d = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (ovalid_q && out_ready) begin
                    ovalid_d = 1'b0;
                    if (row_q != ROW_LAST) begin
                        row_d   = row_q + ROWB'(1);
                        state_d = READ;
                    end else begin
                        fdone_d = 1'b1;
                        if (cont) begin
                            state_d = ERASE;
                            cnt_d   = '0;
                            exp_d   = exp_eff;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            exp_q    <= '0;
            row_q    <= '0;
            odata_q  <= '0;
            orow_q   <= '0;
            ovalid_q <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            row_q    <= row_d;
            odata_q  <= odata_d;
            orow_q   <= orow_d;
            ovalid_q <= ovalid_d;
            fdone_q  <= fdone_d;
        end
    end

    assign erase      = (state_q == ERASE);
    assign expose     = (state_q == EXPOSE);
    assign convert    = (state_q == CONVERT);
    assign busy       = (state_q != IDLE);
    assign out_data   = odata_q;
    assign out_row    = orow_q;
    assign out_valid  = ovalid_q;
    assign frame_done = fdone_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Bench for pixel_frame_ctrl: directed scenarios plus randomized frames,
// with a cycle monitor checking phase lengths, bus codes and the output stream.
module tb_pixel_frame_ctrl;

    localparam int DW        = 8;
    localparam int NROWS     = 2;
    localparam int NCOLS     = 2;
    localparam int ERASE_CYC = 5;
    localparam int EXP_W     = 16;
    localparam int RW        = NCOLS * DW;
    localparam int ROWB      = 1;
    localparam int EW        = ROWB + RW;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               cont;
    logic [EXP_W-1:0]   exp_cycles;
    logic               erase, expose, convert;
    logic [NROWS-1:0]   read;
    logic               anaBias1, anaRamp;
    wire  [NROWS*RW-1:0] pix;
    logic [RW-1:0]      out_data;
    logic [ROWB-1:0]    out_row;
    logic               out_valid;
    logic               out_ready;
    logic               frame_done;
    logic               busy;
    logic [2:0]         dbg_state;

    // pixel array model values, one per row
    logic [RW-1:0]      pat [NROWS];
    int                 ready_mode;

    // scoreboard state
    int                 n_checks = 0;
    int                 n_errors = 0;
    logic [EW-1:0]      exp_q[$];
    int                 exp_len_q[$];
    int                 frames_seen = 0;
    int                 exp_frames = 0;

    // monitor state
    int                 er_run = 0, ex_run = 0, cv_run = 0, exp_row = 0;
    logic [DW-1:0]      last_code;
    logic               prev_valid = 0, prev_hs = 0, prev_fd = 0;
    logic [RW-1:0]      prev_data = '0;
    logic [ROWB-1:0]    prev_row = '0;

    pixel_frame_ctrl #(
        .DW(DW), .NROWS(NROWS), .NCOLS(NCOLS), .ERASE_CYC(ERASE_CYC), .EXP_W(EXP_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cont(cont), .exp_cycles(exp_cycles),
        .erase(erase), .expose(expose), .convert(convert), .read(read),
        .anaBias1(anaBias1), .anaRamp(anaRamp), .pixData(pix),
        .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
        .out_ready(out_ready), .frame_done(frame_done), .busy(busy),
        .state_dbg(dbg_state)
    );

    // clock / pixel array model: a row drives its values only while read
    always #5 clk = ~clk;

    for (genvar r = 0; r < NROWS; r++) begin : g_pix
        assign pix[r*RW +: RW] = read[r] ? pat[r] : {RW{1'bz}};
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // consumer ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // cycle monitor: phase lengths, ramp codes on the bus, row order, stream
    always @(negedge clk) begin : mon
        logic [DW-1:0] code_exp;
        logic [EW-1:0] e;
        int            ridx;
        logic          hs;
        if (reset) begin
            er_run = 0; ex_run = 0; cv_run = 0; exp_row = 0;
            prev_valid = 0; prev_hs = 0; prev_fd = 0;
        end else begin
            code_exp = convert ? DW'(cv_run) : '0;
            for (int r = 0; r < NROWS; r++) begin
                if (!read[r]) begin
                    for (int c = 0; c < NCOLS; c++)
                        check_eq("bus_code", pix[r*RW + c*DW +: DW], code_exp);
                end
            end
            check_eq("phase_excl", 64'(erase) + 64'(expose) + 64'(convert) + 64'(|read) <= 1, 1);

            if (erase) er_run++;
            else if (er_run != 0) begin
                check_eq("erase_len", er_run, ERASE_CYC);
                er_run = 0;
            end

            if (expose) ex_run++;
            else if (ex_run != 0) begin
                if (exp_len_q.size() == 0) check_eq("expose_unexpected", ex_run, 0);
                else check_eq("expose_len", ex_run, exp_len_q.pop_front());
                ex_run = 0;
            end

            if (convert) begin
                last_code = pix[DW-1:0];
                cv_run++;
            end else if (cv_run != 0) begin
                check_eq("convert_len", cv_run, 1 << DW);
                check_eq("convert_last_code", last_code, (1 << DW) - 1);
                cv_run  = 0;
                exp_row = 0;
            end

            if (read != '0) begin
                check_eq("read_onehot", $countones(read), 1);
                ridx = 0;
                for (int i = 0; i < NROWS; i++) if (read[i]) ridx = i;
                check_eq("read_no_valid", out_valid, 0);
                if (exp_row >= NROWS) check_eq("read_extra_row", exp_row, NROWS - 1);
                else begin
                    check_eq("read_row", ridx, exp_row);
                    exp_q.push_back({ROWB'(exp_row), pat[exp_row]});
                    exp_row++;
                end
            end

            hs = out_valid && out_ready;
            if (prev_valid && !prev_hs) begin
                check_eq("valid_held", out_valid, 1);
                check_eq("hold_data", out_data, prev_data);
                check_eq("hold_row", out_row, prev_row);
            end
            if (hs) begin
                if (exp_q.size() == 0) check_eq("unexpected_out", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    check_eq("out_row", out_row, e[EW-1 -: ROWB]);
                    check_eq("out_data", out_data, e[RW-1:0]);
                end
            end
            if (frame_done) begin
                check_eq("fd_after_last", prev_hs && (prev_row == ROWB'(NROWS - 1)), 1);
                check_eq("fd_single", prev_fd, 0);
                frames_seen++;
            end
            if (erase || expose || convert || (|read) || out_valid)
                check_eq("busy_active", busy, 1);

            prev_valid = out_valid;
            prev_hs    = hs;
            prev_data  = out_data;
            prev_row   = out_row;
            prev_fd    = frame_done;
        end
    end

    // driver tasks
    task automatic reset_checks();
        check_eq("rst_erase", erase, 0);
        check_eq("rst_expose", expose, 0);
        check_eq("rst_convert", convert, 0);
        check_eq("rst_read", read, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_row", out_row, 0);
        check_eq("rst_bus", pix, 0);
        check_eq("rst_anaRamp", anaRamp, 0);
        check_eq("rst_anaBias1", anaBias1, 0);
        check_eq("rst_dbg_state", dbg_state, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_to_erase", erase, 1);
    endtask

    task automatic wait_frame_done(input int budget);
        int n = 0;
        while (!frame_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("frame_done_seen", frame_done, 1);
    endtask

    task automatic wait_row_valid(input int row, input int budget);
        int n = 0;
        while (!(out_valid && out_row == ROWB'(row)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("row_valid_seen", out_valid && out_row == ROWB'(row), 1);
    endtask

    task automatic setup_frame(input int e);
        exp_cycles = EXP_W'(e);
        exp_len_q.push_back((e == 0) ? 1 : e);
    endtask

    task automatic run_frame(input int e, input int rmode);
        for (int r = 0; r < NROWS; r++) pat[r] = RW'($urandom);
        ready_mode = rmode;
        setup_frame(e);
        pulse_start();
        wait_frame_done(3000);
        exp_frames++;
        @(negedge clk);
        check_eq("idle_after_frame", busy, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; cont = 1'b0; exp_cycles = '0; ready_mode = 0;
        pat[0] = 16'hA53C; pat[1] = 16'hFF11;
        repeat (3) @(negedge clk);
        reset_checks();
        #2 reset = 1'b0;

        // basic frame
        setup_frame(10);
        pulse_start();
        n = 0;
        while (!expose && n < 50) begin @(negedge clk); n++; end
        #6;
        check_eq("anaBias1_gated", anaBias1, 1);
        check_eq("anaRamp_idle", anaRamp, 0);
        n = 0;
        while (!convert && n < 50) begin @(negedge clk); n++; end
        #6;
        check_eq("anaRamp_gated", anaRamp, 1);
        wait_row_valid(0, 600);
        check_eq("basic_row0", out_data, 16'hA53C);
        wait_row_valid(1, 20);
        check_eq("basic_row1", out_data, 16'hFF11);
        wait_frame_done(20);
        exp_frames++;
        @(negedge clk);
        check_eq("basic_idle", busy, 0);

        // backpressure on row 0
        ready_mode = 2;
        setup_frame(10);
        pulse_start();
        wait_row_valid(0, 600);
        repeat (20) begin
            @(negedge clk);
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_data", out_data, 16'hA53C);
            check_eq("bp_row", out_row, 0);
            check_eq("bp_read", read, 0);
        end
        ready_mode = 0;
        wait_frame_done(100);
        exp_frames++;
        @(negedge clk);
        check_eq("bp_idle", busy, 0);

        // zero exposure, start pulses during EXPOSE ignored
        setup_frame(0);
        pulse_start();
        n = 0;
        while (!expose && n < 50) begin @(negedge clk); n++; end
        check_eq("exp0_expose_seen", expose, 1);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_frame_done(600);
        exp_frames++;
        repeat (5) begin
            @(negedge clk);
            check_eq("exp0_no_restart", busy, 0);
        end

        // continuous mode, exposure change applies to the second frame
        cont = 1'b1;
        setup_frame(5);
        pulse_start();
        wait_row_valid(1, 600);
        exp_cycles = 16'd3;
        exp_len_q.push_back(3);
        wait_frame_done(20);
        exp_frames++;
        check_eq("cont_erase_overlap", erase, 1);
        check_eq("cont_busy", busy, 1);
        cont = 1'b0;
        @(negedge clk);
        wait_frame_done(600);
        exp_frames++;
        @(negedge clk);
        check_eq("cont_idle", busy, 0);

        // reset in the middle of conversion
        setup_frame(2);
        pulse_start();
        n = 0;
        while (!(convert && pix[DW-1:0] == 8'h80) && n < 600) begin @(negedge clk); n++; end
        check_eq("code_0x80_seen", pix[DW-1:0], 8'h80);
        #2 reset = 1'b1;
        #1 reset_checks();
        exp_q.delete();
        exp_len_q.delete();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("idle_after_reset", busy, 0);
        end
        run_frame(10, 0);

        // randomized frames
        for (int i = 0; i < 6; i++)
            run_frame($urandom_range(0, 12), $urandom_range(0, 1));

        check_eq("frames_total", frames_seen, exp_frames);
        check_eq("out_q_drained", exp_q.size(), 0);
        check_eq("exp_len_q_drained", exp_len_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
